// File: rtl/drum_step_sequencer.sv
// Step sequencer for the drum voices: free-running sample-rate divider plus a
// per-step pattern walker that emits one-cycle go pulses to the voice counters.
module drum_step_sequencer #(
    parameter int CLK_DIV = 1042,
    parameter int VOICES  = 4,
    parameter int STEPS   = 16,
    parameter int STEP_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [15:0]               step_len,
    input  logic [VOICES*STEPS-1:0]   pattern,
    output logic                      sample_en,
    output logic [VOICES-1:0]         go_out,
    output logic [STEP_W-1:0]         step,
    output logic                      playing
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                      state, state_nxt;
    logic [15:0]                 div_cnt;
    logic [15:0]                 tick_cnt, tick_nxt;
    logic [15:0]                 step_len_q, len_nxt;
    logic [15:0]                 last_tick;
    logic [STEP_W-1:0]           step_nxt, col_step;
    logic [VOICES-1:0]           go_nxt, col;
    logic                        play_nxt, boundary;
    logic [VOICES-1:0][STEPS-1:0] pat_2d;

    assign pat_2d = pattern;

    // Divider runs regardless of run so the voices always get their sample rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            sample_en <= 1'b0;
        end else begin
            sample_en <= (div_cnt == DIV_LAST);
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 16'd1;
        end
    end

    // Step length 0 behaves as 1: boundary on every tick.
    assign last_tick = (step_len_q == 16'd0) ? 16'd0 : step_len_q - 16'd1;
    assign boundary  = (tick_cnt == last_tick);
    assign col_step  = (state == PLAY) ? step + 1'b1 : '0;

    for (genvar v = 0; v < VOICES; v++) begin : g_col
        assign col[v] = pat_2d[v][col_step];
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        step_nxt  = step;
        len_nxt   = step_len_q;
        go_nxt    = '0;
        play_nxt  = playing;
        case (state)
            IDLE: begin
                tick_nxt = '0;
                step_nxt = '0;
                play_nxt = 1'b0;
                if (run && sample_en) begin
                    state_nxt = PLAY;
                    len_nxt   = step_len;
                    go_nxt    = col;
                    play_nxt  = 1'b1;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_nxt = IDLE;
                    tick_nxt  = '0;
                    step_nxt  = '0;
                    play_nxt  = 1'b0;
                end else if (sample_en) begin
                    if (boundary) begin
                        tick_nxt = '0;
                        step_nxt = col_step;
                        len_nxt  = step_len;
                        go_nxt   = col;
                    end else begin
                        tick_nxt = tick_cnt + 16'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            step_len_q <= '0;
            step       <= '0;
            go_out     <= '0;
            playing    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            step_len_q <= len_nxt;
            step       <= step_nxt;
            go_out     <= go_nxt;
            playing    <= play_nxt;
        end
    end
endmodule

// File: tb/tb_drum_step_sequencer.sv
// Bench for drum_step_sequencer: tick/step-level reference model compared every
// cycle, plus directed timing checks with hand-computed cycle numbers.
module tb_drum_step_sequencer;
    localparam int CLK_DIV = 4;
    localparam int VOICES  = 4;
    localparam int STEPS   = 16;
    localparam int STEP_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    run;
    logic [15:0]             step_len;
    logic [VOICES*STEPS-1:0] pattern;
    logic                    sample_en;
    logic [VOICES-1:0]       go_out;
    logic [STEP_W-1:0]       step;
    logic                    playing;

    int checks = 0;
    int errors = 0;
    int k = 0;

    drum_step_sequencer #(
        .CLK_DIV(CLK_DIV), .VOICES(VOICES), .STEPS(STEPS), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .step_len(step_len),
        .pattern(pattern), .sample_en(sample_en), .go_out(go_out),
        .step(step), .playing(playing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Counts ticks remaining in the current step rather than ticks elapsed.
    int                m_cyc, m_left;
    logic              m_se, m_play;
    logic [STEP_W-1:0] m_step;
    logic [VOICES-1:0] m_go;

    function automatic logic [VOICES-1:0] col_of(input logic [VOICES*STEPS-1:0] p, input int s);
        logic [VOICES*STEPS-1:0] t;
        logic [VOICES-1:0] g;
        g = '0;
        for (int v = 0; v < VOICES; v++) begin
            t = p >> (v * STEPS + s);
            g = {t[0], g[VOICES-1:1]};
        end
        return g;
    endfunction

    function automatic int len_of(input logic [15:0] x);
        return (x == 16'd0) ? 1 : int'(x);
    endfunction

    always @(posedge clk or posedge reset) begin
        logic se_now;
        if (reset) begin
            m_cyc = 0; m_left = 0; m_se = 1'b0; m_play = 1'b0; m_step = '0; m_go = '0;
        end else begin
            se_now = m_se;
            m_cyc++;
            m_se = (m_cyc % CLK_DIV == 0);
            m_go = '0;
            if (!m_play) begin
                if (run && se_now) begin
                    m_play = 1'b1;
                    m_step = '0;
                    m_left = len_of(step_len);
                    m_go   = col_of(pattern, 0);
                end
            end else if (!run) begin
                m_play = 1'b0;
                m_step = '0;
            end else if (se_now) begin
                m_left--;
                if (m_left == 0) begin
                    m_step = m_step + 1'b1;
                    m_left = len_of(step_len);
                    m_go   = col_of(pattern, int'(m_step));
                end
            end
        end
        #1;
        chk("model_sample_en", 32'(sample_en), 32'(m_se));
        chk("model_go_out",    32'(go_out),    32'(m_go));
        chk("model_step",      32'(step),      32'(m_step));
        chk("model_playing",   32'(playing),   32'(m_play));
    end

    // ---------------- directed stimulus ----------------
    task automatic nedge();
        @(negedge clk);
        k++;
    endtask

    task automatic wait_to(input int t);
        while (k < t) nedge();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        k = 0;
    endtask

    initial begin
        int r;
        reset = 1'b1; run = 1'b0; step_len = 16'd1; pattern = '0;
        repeat (2) @(negedge clk);
        chk("reset_go", 32'(go_out), 32'h0);
        chk("reset_playing", 32'(playing), 32'h0);

        // Divider with run low
        reset = 1'b0; k = 0;
        for (int i = 1; i <= 12; i++) begin
            nedge();
            chk("div_sample_en", 32'(sample_en), 32'((k % 4) == 0));
            chk("div_go_idle", 32'(go_out), 32'h0);
            chk("div_playing", 32'(playing), 32'h0);
        end

        // Start and first boundary
        do_reset();
        step_len = 16'd3;
        pattern  = 64'h0000_0000_0002_0001;
        wait_to(9); run = 1'b1;
        wait_to(13);
        chk("start_go", 32'(go_out), 32'h1);
        chk("start_step", 32'(step), 32'h0);
        chk("start_playing", 32'(playing), 32'h1);
        wait_to(14);
        chk("start_go_one_cycle", 32'(go_out), 32'h0);
        wait_to(24);
        chk("pre_boundary_step", 32'(step), 32'h0);
        wait_to(25);
        chk("boundary_go", 32'(go_out), 32'h2);
        chk("boundary_step", 32'(step), 32'h1);

        // Wrap 15 -> 0 with step_len=1
        run = 1'b0;
        do_reset();
        step_len = 16'd1;
        pattern  = 64'h0000_8001_0000_0000;
        run = 1'b1;
        wait_to(61);
        chk("wrap_step14", 32'(step), 32'd14);
        chk("wrap_go14", 32'(go_out), 32'h0);
        wait_to(65);
        chk("wrap_step15", 32'(step), 32'd15);
        chk("wrap_go15", 32'(go_out), 32'h4);
        wait_to(66);
        chk("wrap_go_low", 32'(go_out), 32'h0);
        wait_to(69);
        chk("wrap_step0", 32'(step), 32'd0);
        chk("wrap_go0", 32'(go_out), 32'h4);

        // Tempo change 3 -> 5 mid-step, then step_len=0
        run = 1'b0;
        do_reset();
        step_len = 16'd3;
        pattern  = {$urandom, $urandom};
        run = 1'b1;
        wait_to(10); step_len = 16'd5;
        wait_to(16);
        chk("tempo_step0_end", 32'(step), 32'd0);
        wait_to(17);
        chk("tempo_step1", 32'(step), 32'd1);
        wait_to(36);
        chk("tempo_step1_long", 32'(step), 32'd1);
        wait_to(37);
        chk("tempo_step2", 32'(step), 32'd2);
        wait_to(38); step_len = 16'd0;
        wait_to(56);
        chk("len0_prev_step", 32'(step), 32'd2);
        wait_to(57);
        chk("len0_step3", 32'(step), 32'd3);
        wait_to(61);
        chk("len0_step4", 32'(step), 32'd4);
        wait_to(65);
        chk("len0_step5", 32'(step), 32'd5);

        // Stop on a boundary cycle, then restart
        run = 1'b0;
        do_reset();
        step_len = 16'd1;
        pattern  = '1;
        run = 1'b1;
        wait_to(12);
        chk("stop_tick_present", 32'(sample_en), 32'h1);
        run = 1'b0;
        wait_to(13);
        chk("stop_go", 32'(go_out), 32'h0);
        chk("stop_step", 32'(step), 32'h0);
        chk("stop_playing", 32'(playing), 32'h0);
        wait_to(14); run = 1'b1;
        wait_to(17);
        chk("restart_go", 32'(go_out), 32'hF);
        chk("restart_step", 32'(step), 32'h0);
        chk("restart_playing", 32'(playing), 32'h1);

        // Async reset at step 7 with a pulse in flight
        run = 1'b0;
        do_reset();
        run = 1'b1;
        wait_to(33);
        chk("areset_pre_step", 32'(step), 32'd7);
        chk("areset_pre_go", 32'(go_out), 32'hF);
        #2 reset = 1'b1;
        #1;
        chk("areset_go", 32'(go_out), 32'h0);
        chk("areset_step", 32'(step), 32'h0);
        chk("areset_playing", 32'(playing), 32'h0);
        chk("areset_se", 32'(sample_en), 32'h0);
        @(negedge clk);
        reset = 1'b0; k = 0; run = 1'b0;
        wait_to(3);
        chk("areset_div_3", 32'(sample_en), 32'h0);
        wait_to(4);
        chk("areset_div_4", 32'(sample_en), 32'h1);

        // Randomized run against the model
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            nedge();
            r = int'($urandom_range(0, 99));
            if (r < 3) run = ~run;
            if (r < 10) step_len = 16'($urandom_range(0, 3));
            if (r == 50 || r == 51) pattern = {$urandom, $urandom};
            if (r == 77) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
